bnn_param_loader: RTL

- Upstream configuration stage for the binary neuron array.
- Accepts parameter bytes from the host over a valid/ready handshake and serialises them MSB-first onto the daisy-chained neuron parameter path (`setup`, `param_in`).
- Shifts exactly the number of bits the chain holds, then flags the array as loaded. Neurons shift one bit per `clk` while `setup` is high.

---
 rtl/bnn_param_loader_pkg.sv | 18 +
 rtl/bnn_param_loader_if.sv | 9 +
 rtl/bnn_param_loader.sv | 86 ++++++++
 3 files changed

// File: rtl/bnn_param_loader_pkg.sv
// Shared types and sizing helpers for the binary neuron array and its parameter loader.
package bnn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_INPUTS    = 8;
  localparam int DEF_BIAS_BITS = 3;

  function automatic int chain_bits(input int neurons, input int inputs, input int bias_bits);
    return neurons * (inputs + bias_bits);
  endfunction

endpackage

// File: rtl/bnn_param_loader_if.sv
// Host byte stream into the parameter loader: valid/ready, byte moves when both are high.
interface bnn_param_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/bnn_param_loader.sv
// Serialises host bytes MSB-first onto the neuron parameter chain; 1 cycle per byte + 8 shifts.
// Backpressure: in_ready only in LOAD; optional chain readback parity under BNN_PARAM_READBACK_EN.
module bnn_param_loader
  import bnn_pkg::*;
#(
  parameter int NEURONS   = 4,
  parameter int INPUTS    = DEF_INPUTS,
  parameter int BIAS_BITS = DEF_BIAS_BITS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  bnn_param_loader_if.slave  host,
  output logic               setup,
  output logic               param_out,
  input  logic               chain_in,
  output logic               busy,
  output logic               loaded,
  output logic               readback_parity
);

  localparam int TOTAL_BITS = chain_bits(NEURONS, INPUTS, BIAS_BITS);
  localparam int CNT_BITS   = $clog2(TOTAL_BITS + 1);
  localparam logic [CNT_BITS-1:0] LAST_BIT = CNT_BITS'(TOTAL_BITS - 1);

  state_t              state;
  logic [7:0]          shreg;
  logic [2:0]          byte_idx;
  logic [CNT_BITS-1:0] bit_cnt;
  logic                rb_par;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      shreg    <= '0;
      byte_idx <= '0;
      bit_cnt  <= '0;
      rb_par   <= 1'b0;
    end else if (start) begin
      // Restart from any state; whatever was shifted so far is simply overwritten.
      state    <= LOAD;
      byte_idx <= '0;
      bit_cnt  <= '0;
      rb_par   <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (host.in_valid) begin
            shreg    <= host.in_data;
            byte_idx <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          shreg    <= shreg << 1;
          byte_idx <= byte_idx + 3'd1;
          bit_cnt  <= bit_cnt + CNT_BITS'(1);
`ifdef BNN_PARAM_READBACK_EN
          rb_par   <= rb_par ^ chain_in;
`endif
          // Chain length need not be a byte multiple: the tail of the last byte is dropped.
          if (bit_cnt == LAST_BIT)
            state <= DONE;
          else if (byte_idx == 3'd7)
            state <= LOAD;
        end
        default: state <= state;
      endcase
    end
  end

  assign host.in_ready = (state == LOAD);
  assign setup         = (state == SHIFT);
  assign param_out     = (state == SHIFT) & shreg[7];
  assign busy          = (state == LOAD) | (state == SHIFT);
  assign loaded        = (state == DONE);

`ifdef BNN_PARAM_READBACK_EN
  assign readback_parity = rb_par;
`else
  logic unused_readback;
  assign unused_readback = chain_in ^ rb_par;
  assign readback_parity = 1'b0;
`endif

endmodule
